// File: rtl/risc_ctrl_seq_pkg.sv
// risc_ctrl_seq_pkg: opcodes, FSM states, phase names and counter sizing for the sequenced control decoder
package ctrl_pkg;
    localparam logic [7:0] OP_HLT = 8'd0, OP_SKZ = 8'd1, OP_ADD = 8'd2, OP_AND = 8'd3;
    localparam logic [7:0] OP_XOR = 8'd4, OP_LDA = 8'd5, OP_STO = 8'd6, OP_JMP = 8'd7;
    localparam logic [7:0] OP_ILL = 8'd8;
    typedef enum logic {ST_RUN, ST_HALT} state_t;
    localparam logic [2:0] P_FETCH0 = 3'd0, P_FETCH1 = 3'd1, P_FETCH2 = 3'd2, P_FETCH3 = 3'd3;
    localparam logic [2:0] P_DECODE4 = 3'd4, P_EXEC5 = 3'd5, P_EXEC6 = 3'd6, P_EXEC7 = 3'd7;
    // the counter only ever holds 0..limit-1 before it traps
    function automatic int wait_w(input int limit);
        return (limit < 2) ? 1 : $clog2(limit);
    endfunction
endpackage

// File: rtl/risc_ctrl_seq_if.sv
// risc_ctrl_seq_if: IR/flag/memory inputs and datapath strobes; step exists only with RISC_CTRL_SINGLE_STEP_EN
interface risc_ctrl_seq_if #(parameter int OPC_W = 3) ();
    logic [OPC_W-1:0] opcode;
    logic zero, mem_ready, resume;
`ifdef RISC_CTRL_SINGLE_STEP_EN
    logic step;
`endif
    logic [2:0] phase;
    logic sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, illegal, timeout;
    modport master (
        output opcode, zero, mem_ready, resume,
`ifdef RISC_CTRL_SINGLE_STEP_EN
        output step,
`endif
        input phase, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, illegal, timeout
    );
    modport slave (
        input opcode, zero, mem_ready, resume,
`ifdef RISC_CTRL_SINGLE_STEP_EN
        input step,
`endif
        output phase, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, illegal, timeout
    );
endinterface

// File: rtl/risc_ctrl_seq_wait_timer.sv
// ctrl_wait_timer: counts consecutive stall cycles and flags the one that reaches WAIT_LIMIT
module ctrl_wait_timer
    import ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    input  logic advance,
    output logic expire
);
    localparam int W = wait_w(WAIT_LIMIT);
    logic [W-1:0] wait_cnt;
    assign expire = (WAIT_LIMIT != 0) && stall && (wait_cnt == W'(WAIT_LIMIT - 1));
    // restart on every advance and after a trap so the next access gets a full budget
    always_ff @(posedge clk or posedge rst)
        if (rst) wait_cnt <= '0;
        else if (advance || expire) wait_cnt <= '0;
        else if (stall) wait_cnt <= wait_cnt + 1'b1;
endmodule

// File: rtl/risc_ctrl_seq.sv
// risc_ctrl_seq: 8-phase accumulator-CPU sequencer with wait states, HALT/resume, traps; optional RISC_CTRL_SINGLE_STEP_EN
module risc_ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int OPC_W        = 3,
    parameter int WAIT_LIMIT   = 15,
    parameter int RESET_HALTED = 0
) (
    input logic clk,
    input logic rst,
    risc_ctrl_seq_if.slave bus
);
    state_t state, state_n;
    logic [2:0] ph, ph_n;
    logic ill_q, ill_n, to_q, to_n, stepping, stepping_n;
    logic [OPC_W-1:0] opc;
    logic [7:0] opx;
    logic h, a, z, j, s, ill, run, mem, stall, expire, step_in;
    assign opc = bus.opcode;
    assign opx = 8'(opc);
    assign h   = opx == OP_HLT;
    assign a   = opx >= OP_ADD && opx <= OP_LDA;
    assign z   = opx == OP_SKZ && bus.zero;
    assign j   = opx == OP_JMP;
    assign s   = opx == OP_STO;
    assign ill = opx >= OP_ILL;
`ifdef RISC_CTRL_SINGLE_STEP_EN
    assign step_in = bus.step;
`else
    assign step_in = 1'b0;
`endif
    assign run   = state == ST_RUN;
    assign mem   = (ph >= P_FETCH1 && ph <= P_FETCH3) || (a && ph >= P_EXEC5) || (s && ph == P_EXEC7);
    assign stall = run && mem && !bus.mem_ready;
    ctrl_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
        .clk(clk), .rst(rst), .stall(stall), .advance(!stall), .expire(expire)
    );
    assign bus.phase   = ph;
    assign bus.illegal = ill_q;
    assign bus.timeout = to_q;
    assign bus.sel     = run && ph <= P_FETCH3;
    assign bus.rd      = run && ((ph >= P_FETCH1 && ph <= P_FETCH3) || (a && ph >= P_EXEC5));
    assign bus.ld_ir   = run && !stall && (ph == P_FETCH2 || ph == P_FETCH3);
    assign bus.inc_pc  = run && !stall && (ph == P_DECODE4 || (z && ph == P_EXEC6));
    assign bus.halt    = !run || (ph == P_DECODE4 && (h || ill));
    assign bus.ld_pc   = run && !stall && j && ph >= P_EXEC6;
    assign bus.data_e  = run && s && ph >= P_EXEC6;
    assign bus.ld_ac   = run && !stall && a && ph == P_EXEC7;
    assign bus.wr      = run && s && ph == P_EXEC7;
    // sequencer state, phase and sticky trap flags
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= (RESET_HALTED != 0) ? ST_HALT : ST_RUN;
            ph       <= P_FETCH0;
            ill_q    <= 1'b0;
            to_q     <= 1'b0;
            stepping <= 1'b0;
        end else begin
            state    <= state_n;
            ph       <= ph_n;
            ill_q    <= ill_n;
            to_q     <= to_n;
            stepping <= stepping_n;
        end
    // resume beats step in HALT; in RUN a timeout, then the p4 halt, then a normal advance
    always_comb begin
        state_n    = state;
        ph_n       = ph;
        ill_n      = ill_q;
        to_n       = to_q;
        stepping_n = stepping;
        if (!run) begin
            if (bus.resume) begin
                state_n    = ST_RUN;
                ill_n      = 1'b0;
                to_n       = 1'b0;
                stepping_n = 1'b0;
            end else if (step_in) begin
                state_n    = ST_RUN;
                stepping_n = 1'b1;
            end
        end else if (expire) begin
            state_n    = ST_HALT;
            ph_n       = P_FETCH0;
            to_n       = 1'b1;
            stepping_n = 1'b0;
        end else if (ph == P_DECODE4 && (h || ill)) begin
            state_n    = ST_HALT;
            ph_n       = P_FETCH0;
            ill_n      = ill_q || ill;
            stepping_n = 1'b0;
        end else if (!stall) begin
            ph_n = ph + 3'd1;
            if (stepping && ph == P_EXEC7) begin
                state_n    = ST_HALT;
                stepping_n = 1'b0;
            end
        end
    end
endmodule
